pico_bus_fabric: RTL
====================

Name: pico_bus_fabric

Overview:
- Parametrised memory-mapped interconnect between the picorv32 native memory port and NUM_SLAVES slave channels.
- Replaces hand-written per-design ready/rdata muxing at the CPU wrapper level.
- Registers the address decode, drives one slave at a time, and waits any number of slave wait-states.
- Terminates decode misses and slave timeouts with an error response, so the CPU never hangs.

Parameters:
- NUM_SLAVES, 4, number of slave channels (1..16).
- SLAVE_BASE, {32'h0001_0000, 32'h0000_8000, 32'h0000_1000, 32'h0000_0000}, packed NUM_SLAVES*32 region bases; slave i occupies bits [32*i+:32].
- SLAVE_MASK, {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F800}, packed address masks; hit when (addr & MASK) == BASE.
- TIMEOUT_CYCLES, 255, maximum cycles in ACCESS; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a miss or a timeout.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cpu_mem_valid  in  1  picorv32 request valid.
- cpu_mem_instr  in  1  instruction fetch flag.
- cpu_mem_addr  in  32  byte address.
- cpu_mem_wdata  in  32  write data.
- cpu_mem_wstrb  in  4  byte strobes; 0 means read.
- cpu_mem_ready  out  1  one-cycle completion pulse.
- cpu_mem_rdata  out  32  registered read data.
- s_valid  out  NUM_SLAVES  one-hot slave request.
- s_addr  out  32  registered address, shared by all slaves.
- s_wdata  out  32  registered write data, shared.
- s_wstrb  out  4  registered strobes, shared.
- s_ready  in  NUM_SLAVES  per-slave completion.
- s_rdata  in  NUM_SLAVES*32  packed slave read data.
- err_pulse  out  1  high with cpu_mem_ready on an errored transfer.
- err_code  out  2  01 = decode miss, 10 = timeout; holds the last error.
- err_addr  out  32  address of the last errored transfer.
- err_count  out  16  saturating error counter.
- dbg_read  out  1  cpu_mem_valid & (cpu_mem_instr | cpu_mem_wstrb == 0).
- dbg_write  out  1  cpu_mem_valid & (cpu_mem_wstrb != 0).

Behaviour:
- Reset: asynchronous, active-low.
  - state = IDLE.
  - All outputs 0, including s_valid, cpu_mem_ready, cpu_mem_rdata, err_*, s_addr, s_wdata and s_wstrb.
- Decode (combinational): lowest matching index wins on overlapping regions. Outputs are hit and sel.
- FSM: IDLE, ACCESS, RESP.
- IDLE:
  - Exit condition: cpu_mem_valid sampled high.
  - On exit, register addr, wdata and wstrb into s_addr, s_wdata and s_wstrb; clear the timeout counter.
  - hit: go to ACCESS; s_valid[sel] is high in the next cycle.
  - miss: go to RESP with cpu_mem_rdata = ERR_RDATA and err_code = 01. No slave is touched, so writes are dropped.
- ACCESS:
  - s_valid[sel] is held high; the counter increments each cycle.
  - s_ready[sel] high: capture s_rdata[sel] into cpu_mem_rdata, drop s_valid, go to RESP.
  - Counter == TIMEOUT_CYCLES-1 without ready (and TIMEOUT_CYCLES != 0): drop s_valid, cpu_mem_rdata = ERR_RDATA, err_code = 10, go to RESP.
  - s_ready of non-selected slaves is ignored.
  - cpu_mem_valid low while in ACCESS (abort): drop s_valid, go to IDLE, no cpu_mem_ready, no error.
- RESP:
  - cpu_mem_ready = 1 for exactly one cycle, then go to IDLE.
  - err_pulse accompanies ready on a miss or a timeout.
  - err_addr updates on errors; err_count increments and saturates at 16'hFFFF.
- Latency:
  - Zero-wait slave (s_ready high in the first ACCESS cycle): cpu_mem_ready in cycle 2 after valid is first sampled in cycle 0.
  - Each slave wait-state adds 1 cycle.
  - Miss: ready in cycle 1.
- Back-to-back: IDLE accepts a new request in the cycle after RESP. cpu_mem_valid seen during RESP is not accepted.
- A late s_ready after a timeout is ignored.
- Reads and writes with wstrb = 0 are identical except for dbg_read/dbg_write.

Decomposition:
- pico_bus_pkg holds:
  - the state enum (IDLE/ACCESS/RESP);
  - the err_code constants ERR_NONE, ERR_MISS, ERR_TIMEOUT;
  - the DEFAULT_ERR_RDATA constant.
- Sub-module pico_bus_region_decode:
  - purely combinational, parametrised by NUM_SLAVES, SLAVE_BASE and SLAVE_MASK;
  - outputs hit and a one-hot select;
  - priority encoding is done in this sub-module.
- The FSM, timeout counter, response registers and error registers live in the top module.

Test Plan:
- Read slave0 at 0x0000_0010, s_ready tied high, s_rdata0 = 0x1234_5678:
  - s_valid = 4'b0001 in cycle 1;
  - cpu_mem_ready in cycle 2 with rdata 0x1234_5678;
  - err_pulse = 0.
- Write slave2 at 0x0000_8004, wstrb = 4'b0011, slave ready after 3 wait cycles:
  - s_wstrb = 0011 and s_wdata are held stable throughout;
  - ready in cycle 5.
- Access 0x0004_0000 (miss):
  - no s_valid;
  - ready in cycle 1 with rdata 0xDEAD_BEEF;
  - err_code = 01, err_addr = 0x0004_0000, err_count = 1.
- TIMEOUT_CYCLES = 4, slave1 never ready:
  - s_valid high for 4 cycles, then ready with 0xDEAD_BEEF and err_code = 10;
  - s_ready pulsed 2 cycles later has no effect.
- Overlap test with SLAVE_BASE1 = SLAVE_BASE0 and identical masks: slave0 is selected.
- Reset asserted mid-ACCESS:
  - s_valid and cpu_mem_ready drop immediately;
  - after release, a fresh request completes normally.

Source files
------------

// File: rtl/pico_bus_pkg.sv
// Shared state encoding and error constants for the picorv32 bus fabric.
package pico_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MISS    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/pico_bus_region_decode.sv
// Combinational address decoder: masked compare per region, lowest index wins.
module pico_bus_region_decode #(
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
        {32'h0001_0000, 32'h0000_8000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F800}
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] sel
);

    // Once a lower region has claimed the address, higher ones are masked off.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                hit    = 1'b1;
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pico_bus_fabric.sv
// picorv32 native-port interconnect: registered decode, one slave at a time,
// error termination of decode misses and slave timeouts.
module pico_bus_fabric
    import pico_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
        {32'h0001_0000, 32'h0000_8000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F800},
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cpu_mem_valid,
    input  logic                       cpu_mem_instr,
    input  logic [31:0]                cpu_mem_addr,
    input  logic [31:0]                cpu_mem_wdata,
    input  logic [3:0]                 cpu_mem_wstrb,
    output logic                       cpu_mem_ready,
    output logic [31:0]                cpu_mem_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    output logic                       err_pulse,
    output logic [1:0]                 err_code,
    output logic [31:0]                err_addr,
    output logic [15:0]                err_count,
    output logic                       dbg_read,
    output logic                       dbg_write
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    bus_state_t              state;
    logic [TW-1:0]           timer;
    logic [NUM_SLAVES-1:0]   sel_q;
    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    sel_ready;
    logic [31:0]             sel_rdata;

    pico_bus_region_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr (cpu_mem_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign sel_ready = |(s_ready & sel_q);
    assign dbg_read  = cpu_mem_valid & (cpu_mem_instr | (cpu_mem_wstrb == 4'd0));
    assign dbg_write = cpu_mem_valid & (cpu_mem_wstrb != 4'd0);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
        end
    end

    // Ready and err_pulse are set on entry to RESP so they are high for that one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            timer         <= '0;
            sel_q         <= '0;
            s_valid       <= '0;
            s_addr        <= '0;
            s_wdata       <= '0;
            s_wstrb       <= '0;
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= '0;
            err_pulse     <= 1'b0;
            err_code      <= ERR_NONE;
            err_addr      <= '0;
            err_count     <= '0;
        end else begin
            cpu_mem_ready <= 1'b0;
            err_pulse     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_mem_valid) begin
                        s_addr  <= cpu_mem_addr;
                        s_wdata <= cpu_mem_wdata;
                        s_wstrb <= cpu_mem_wstrb;
                        timer   <= '0;
                        if (dec_hit) begin
                            sel_q   <= dec_sel;
                            s_valid <= dec_sel;
                            state   <= ACCESS;
                        end else begin
                            cpu_mem_rdata <= ERR_RDATA;
                            err_code      <= ERR_MISS;
                            err_addr      <= cpu_mem_addr;
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            cpu_mem_ready <= 1'b1;
                            err_pulse     <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    timer <= timer + TW'(1);
                    if (!cpu_mem_valid) begin
                        s_valid <= '0;
                        state   <= IDLE;
                    end else if (sel_ready) begin
                        cpu_mem_rdata <= sel_rdata;
                        s_valid       <= '0;
                        cpu_mem_ready <= 1'b1;
                        state         <= RESP;
                    end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
                        s_valid       <= '0;
                        cpu_mem_rdata <= ERR_RDATA;
                        err_code      <= ERR_TIMEOUT;
                        err_addr      <= s_addr;
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        cpu_mem_ready <= 1'b1;
                        err_pulse     <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
